// File: rtl/led_sequencer_pkg.sv
// Shared mode encoding and small helpers for the LED sequencer.
package led_sequencer_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;

  typedef enum logic [1:0] {
    ModeManual = MODE_MANUAL,
    ModeChase  = MODE_CHASE,
    ModeBlink  = MODE_BLINK
  } mode_e;

  // Mode advance order: MANUAL -> CHASE -> BLINK -> MANUAL.
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      ModeManual: return ModeChase;
      ModeChase:  return ModeBlink;
      default:    return ModeManual;
    endcase
  endfunction

  // One-hot rotate with wrap; up moves the lit LED towards LED3.
  function automatic logic [3:0] rotate(input logic [3:0] pat, input logic up);
    return up ? {pat[2:0], pat[3]} : {pat[0], pat[3:1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchroniser, polarity normalisation and debounce with press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press_evt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sample;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // 1 = pressed, independent of the pin polarity.
  assign sample = sync_q[1] ^ ACTIVE_LOW;

  // Count consecutive samples that disagree with the accepted state; flip once enough agree.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = cnt_q;
    if (sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = ~stable_q;
      press_d  = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Synchroniser and debounce state; sync flops reset to the released pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {2{ACTIVE_LOW}};
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable    = stable_q;
  assign press_evt = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Button-driven LED controller: debounced inputs, MANUAL/CHASE/BLINK mode FSM, registered LEDs.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned TICK_CYCLES     = 3000000,
  parameter logic [3:0]  BTN_ACTIVE_LOW  = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BOTON0,
  input  logic       BOTON1,
  input  logic       BOTON2,
  input  logic       BOTON3,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic [1:0] mode
);

  localparam int unsigned TickW = $clog2(TICK_CYCLES);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_stable;
  logic [3:0] press_evt;
  logic       unused_stable;

  assign btn_raw       = {BOTON3, BOTON2, BOTON1, BOTON0};
  assign unused_stable = ^btn_stable;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BTN_ACTIVE_LOW[i])
    ) u_btn_debounce (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[i]),
      .stable   (btn_stable[i]),
      .press_evt(press_evt[i])
    );
  end

  mode_e            mode_q, mode_d;
  logic [2:0]       latch_q, latch_d;
  logic [3:0]       pattern_q, pattern_d;
  logic             dir_up_q, dir_up_d;
  logic             paused_q, paused_d;
  logic             phase_q, phase_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       led_q, led_d;
  logic             tick;

  assign tick = (tick_cnt_q == TickLast);

  // Next-state for mode, per-mode state, prescaler and the LED image derived from next-state.
  always_comb begin
    mode_d     = mode_q;
    latch_d    = latch_q;
    pattern_d  = pattern_q;
    dir_up_d   = dir_up_q;
    paused_d   = paused_q;
    phase_d    = phase_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    led_d      = '0;

    if (press_evt[3]) begin
      // Mode advance wins over any other button in the same cycle.
      mode_d     = next_mode(mode_q);
      tick_cnt_d = '0;
      if (mode_d == ModeChase) begin
        pattern_d = 4'b0001;
        dir_up_d  = 1'b1;
        paused_d  = 1'b0;
      end
      if (mode_d == ModeBlink) begin
        phase_d = 1'b1;
      end
    end else begin
      unique case (mode_q)
        ModeManual: latch_d = latch_q ^ press_evt[2:0];
        ModeChase: begin
          dir_up_d = dir_up_q ^ press_evt[0];
          paused_d = paused_q ^ press_evt[1];
          // A coincident direction flip applies to this very step.
          if (tick && !paused_q) begin
            pattern_d = rotate(pattern_q, dir_up_d);
          end
        end
        ModeBlink: begin
          if (tick) begin
            phase_d = ~phase_q;
          end
        end
        default: mode_d = ModeManual;
      endcase
    end

    unique case (mode_d)
      ModeManual: led_d = {1'b0, latch_d};
      ModeChase:  led_d = pattern_d;
      ModeBlink:  led_d = {4{phase_d}};
      default:    led_d = '0;
    endcase
  end

  // State and LED registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= ModeManual;
      latch_q    <= 3'b000;
      pattern_q  <= 4'b0001;
      dir_up_q   <= 1'b1;
      paused_q   <= 1'b0;
      phase_q    <= 1'b1;
      tick_cnt_q <= '0;
      led_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      latch_q    <= latch_d;
      pattern_q  <= pattern_d;
      dir_up_q   <= dir_up_d;
      paused_q   <= paused_d;
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      led_q      <= led_d;
    end
  end

  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];
  assign LED3 = led_q[3];
  assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer with short debounce/tick settings.
module tb_led_sequencer;

  localparam logic [3:0] ACT_LOW = 4'b0111;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [1:0] mode;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       BOTON0 = 1'b1, BOTON1 = 1'b1, BOTON2 = 1'b1, BOTON3 = 1'b0;
  logic       LED0, LED1, LED2, LED3;
  logic [1:0] mode;
  logic [3:0] leds;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  led_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (8),
    .BTN_ACTIVE_LOW (ACT_LOW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .BOTON0(BOTON0),
    .BOTON1(BOTON1),
    .BOTON2(BOTON2),
    .BOTON3(BOTON3),
    .LED0  (LED0),
    .LED1  (LED1),
    .LED2  (LED2),
    .LED3  (LED3),
    .mode  (mode)
  );

  assign leds = {LED3, LED2, LED1, LED0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int c, input logic [3:0] l, input logic [1:0] m,
                                    input string n);
    exp_t e;
    e.cyc = c; e.led = l; e.mode = m; e.name = n;
    sb.push_back(e);
  endfunction

  task automatic set_btn(input int i, input bit pressed);
    logic v;
    v = pressed ^ ACT_LOW[i];
    case (i)
      0: BOTON0 = v;
      1: BOTON1 = v;
      2: BOTON2 = v;
      default: BOTON3 = v;
    endcase
  endtask

  task automatic test_reset();
    int   base;
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;
    for (int k = 0; k < 20; k++) expect_at(base + k, 4'b0000, 2'd0, "reset_idle");
    for (int k = 0; k < 22; k++) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (leds !== e.led || mode !== e.mode) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got led=%b mode=%0d want led=%b mode=%0d",
                   e.name, cyc, leds, mode, e.led, e.mode);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL reset_leftover got %0d pending want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_manual();
    int   base;
    exp_t e;
    base = cyc;
    expect_at(base + 6,  4'b0000, 2'd0, "manual_before_press");
    expect_at(base + 7,  4'b0001, 2'd0, "manual_press_latency");
    expect_at(base + 30, 4'b0001, 2'd0, "manual_before_2nd");
    expect_at(base + 31, 4'b0000, 2'd0, "manual_2nd_toggle");
    expect_at(base + 54, 4'b0000, 2'd0, "manual_before_3rd");
    expect_at(base + 55, 4'b0001, 2'd0, "manual_3rd_toggle");
    expect_at(base + 76, 4'b0001, 2'd0, "glitch_a");
    expect_at(base + 80, 4'b0001, 2'd0, "glitch_b");
    expect_at(base + 88, 4'b0001, 2'd0, "glitch_c");
    for (int k = 0; k < 90; k++) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (leds !== e.led || mode !== e.mode) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got led=%b mode=%0d want led=%b mode=%0d",
                   e.name, cyc, leds, mode, e.led, e.mode);
        end
      end
      case (k)
        0, 24, 48: set_btn(0, 1'b1);
        12, 36, 60: set_btn(0, 1'b0);
        70: set_btn(1, 1'b1);
        73: set_btn(1, 1'b0);
        default: ;
      endcase
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL manual_leftover got %0d pending want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_chase();
    int   base;
    exp_t e;
    base = cyc;
    expect_at(base + 6,   4'b0001, 2'd0, "chase_pre_entry");
    expect_at(base + 7,   4'b0001, 2'd1, "chase_entry");
    expect_at(base + 14,  4'b0001, 2'd1, "chase_hold");
    expect_at(base + 15,  4'b0010, 2'd1, "chase_step1");
    expect_at(base + 23,  4'b0100, 2'd1, "chase_step2");
    expect_at(base + 31,  4'b1000, 2'd1, "chase_step3");
    expect_at(base + 39,  4'b0001, 2'd1, "chase_wrap_up");
    expect_at(base + 63,  4'b1000, 2'd1, "chase_at_1000");
    expect_at(base + 67,  4'b1000, 2'd1, "chase_dir_no_move");
    expect_at(base + 71,  4'b0100, 2'd1, "chase_reversed");
    expect_at(base + 79,  4'b0010, 2'd1, "chase_down2");
    expect_at(base + 95,  4'b0001, 2'd1, "pause_tick1");
    expect_at(base + 103, 4'b0001, 2'd1, "pause_tick2");
    expect_at(base + 111, 4'b0001, 2'd1, "pause_tick3");
    expect_at(base + 115, 4'b0001, 2'd1, "resume_no_move");
    expect_at(base + 119, 4'b1000, 2'd1, "resume_wrap_down");
    expect_at(base + 127, 4'b0100, 2'd1, "resume_step");
    for (int k = 0; k < 130; k++) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (leds !== e.led || mode !== e.mode) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got led=%b mode=%0d want led=%b mode=%0d",
                   e.name, cyc, leds, mode, e.led, e.mode);
        end
      end
      case (k)
        0: set_btn(3, 1'b1);
        12: set_btn(3, 1'b0);
        60: set_btn(0, 1'b1);
        72: set_btn(0, 1'b0);
        84, 108: set_btn(1, 1'b1);
        96, 120: set_btn(1, 1'b0);
        default: ;
      endcase
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL chase_leftover got %0d pending want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_blink();
    int   base;
    exp_t e;
    base = cyc;
    expect_at(base + 7,  4'b1111, 2'd2, "blink_entry");
    expect_at(base + 14, 4'b1111, 2'd2, "blink_hold");
    expect_at(base + 15, 4'b0000, 2'd2, "blink_off");
    expect_at(base + 23, 4'b1111, 2'd2, "blink_on");
    expect_at(base + 37, 4'b0001, 2'd0, "manual_latch_kept");
    expect_at(base + 45, 4'b0001, 2'd0, "manual_latch_stays");
    for (int k = 0; k < 50; k++) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (leds !== e.led || mode !== e.mode) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got led=%b mode=%0d want led=%b mode=%0d",
                   e.name, cyc, leds, mode, e.led, e.mode);
        end
      end
      case (k)
        0, 30: set_btn(3, 1'b1);
        12, 42: set_btn(3, 1'b0);
        default: ;
      endcase
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL blink_leftover got %0d pending want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int   base;
    exp_t e;
    base = cyc;
    expect_at(base + 7,  4'b0001, 2'd1, "mid_chase_entry");
    expect_at(base + 15, 4'b0010, 2'd1, "mid_chase_step");
    expect_at(base + 18, 4'b0010, 2'd1, "mid_before_rst");
    expect_at(base + 19, 4'b0000, 2'd0, "mid_rst_applied");
    expect_at(base + 22, 4'b0000, 2'd0, "mid_after_rst");
    expect_at(base + 28, 4'b0000, 2'd0, "mid_latch_cleared");
    for (int k = 0; k < 30; k++) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (leds !== e.led || mode !== e.mode) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got led=%b mode=%0d want led=%b mode=%0d",
                   e.name, cyc, leds, mode, e.led, e.mode);
        end
      end
      case (k)
        0: set_btn(3, 1'b1);
        12: set_btn(3, 1'b0);
        18: rst = 1'b1;
        20: rst = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL mid_leftover got %0d pending want 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_chase();
    test_blink();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
